// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scans a 4x4 active-low matrix keypad one row at a time and debounces the
// result frame by frame. Exactly one accepted key at a time reaches the meter
// core as a 4-bit code on num, qualified by the active-low strobe Anti. Bounce
// is rejected. Multi-key presses, including ghost patterns, are also rejected,
// so the core sees one clean falling edge per keystroke.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to enable autorepeat. With it,
// a key held for REPEAT_FRAMES frames raises Anti for one frame and then drops
// it again. Without it, one press gives one falling edge and REPEAT_FRAMES is
// ignored.
//
// Parameters
//   SCAN_DIV        clocks per row step (>= 4)
//   DEBOUNCE_FRAMES identical frames needed to accept or release (>= 1)
//   REPEAT_FRAMES   held frames per autorepeat event
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous reset, active low
//   col_n  in   [3:0] keypad columns, active low, asynchronous
//   row_n  out  [3:0] row drive, one-hot active low
//   num    out  [3:0] code of the accepted key, stable while Anti = 0
//   Anti   out  key strobe: 1 idle, 0 while the accepted key is held
//   ghost  out  one-clock pulse after any frame with more than one key down
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_FRAMES   = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] num,
   output logic       Anti,
   output logic       ghost
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int RW = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(SCAN_DIV - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic RPT_EN = 1'b1;
`else
   localparam logic RPT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      CONFIRM,
      ARM,
      HELD,
      GAP
   } state_t;

   // Key legend, row-major: 1 2 3 B / 4 5 6 C / 7 8 9 D / E 0 F A
   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'd0:  code = 4'd1;
         4'd1:  code = 4'd2;
         4'd2:  code = 4'd3;
         4'd3:  code = 4'd11;
         4'd4:  code = 4'd4;
         4'd5:  code = 4'd5;
         4'd6:  code = 4'd6;
         4'd7:  code = 4'd12;
         4'd8:  code = 4'd7;
         4'd9:  code = 4'd8;
         4'd10: code = 4'd9;
         4'd11: code = 4'd13;
         4'd12: code = 4'd14;
         4'd13: code = 4'd0;
         4'd14: code = 4'd15;
         default: code = 4'd10;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] key_count(input logic [3:0] k);
      return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
   endfunction

   // Only meaningful when exactly one bit is set.
   function automatic logic [1:0] col_index(input logic [3:0] k);
      logic [1:0] idx;
      case (k)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   logic [3:0]    col_p0, col_p1;
   logic [SW-1:0] step_cnt;
   logic [1:0]    row_idx;
   logic          sample_en, frame_end;

   logic [3:0]    row_keys;
   logic          row_hit;
   logic          acc_any, acc_multi;
   logic [3:0]    acc_code;
   logic          mrg_any, mrg_multi;
   logic [3:0]    mrg_code;
   logic          res_single, res_multi;
   logic [3:0]    res_code;

   state_t        state, state_nxt;
   logic [MW-1:0] match_cnt, match_nxt;
   logic [MW-1:0] rel_cnt, rel_nxt;
   logic [RW-1:0] rpt_cnt, rpt_nxt;
   logic [3:0]    cand, cand_nxt;
   logic [3:0]    num_nxt;
   logic          anti_nxt;
   logic          key_hold, rel_done, match_done, rpt_done;

   // ---- stage p0/p1: column synchronizer
   always_ff @(posedge clk) begin
      col_p0 <= col_n;
      col_p1 <= col_p0;
   end

   // ---- row stepping: column sample on the last count, then rotate the row
   assign sample_en = (step_cnt == STEP_LAST);
   assign frame_end = sample_en && (row_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_cnt <= '0;
         row_idx  <= 2'd0;
         row_n    <= 4'b1110;
      end else if (sample_en) begin
         step_cnt <= '0;
         row_idx  <= row_idx + 2'd1;
         row_n    <= {row_n[2:0], row_n[3]};
      end else begin
         step_cnt <= step_cnt + 1'b1;
      end
   end

   // ---- frame accumulation: the current row's sample merged with earlier rows
   // A second key anywhere in the frame, in the same row or another row,
   // turns the whole frame into MULTI.
   assign row_keys  = ~col_p1;
   assign row_hit   = |row_keys;
   assign mrg_multi = acc_multi | (key_count(row_keys) > 3'd1) | (acc_any & row_hit);
   assign mrg_any   = acc_any | row_hit;
   assign mrg_code  = (row_hit && !acc_any) ? key_code(row_idx, col_index(row_keys)) : acc_code;

   assign res_single = mrg_any & ~mrg_multi;
   assign res_multi  = mrg_multi;
   assign res_code   = mrg_code;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_any   <= 1'b0;
         acc_multi <= 1'b0;
      end else if (frame_end) begin
         acc_any   <= 1'b0;
         acc_multi <= 1'b0;
      end else if (sample_en) begin
         acc_any   <= mrg_any;
         acc_multi <= mrg_multi;
      end
   end

   always_ff @(posedge clk) begin
      if (sample_en) begin
         acc_code <= mrg_code;
      end
   end

   // ---- debounce FSM, acting on frame results
   assign key_hold   = res_single && (res_code == num);
   assign rel_done   = (int'(rel_cnt) + 1) >= DEBOUNCE_FRAMES;
   assign match_done = (int'(match_cnt) + 1) >= DEBOUNCE_FRAMES;
   assign rpt_done   = (int'(rpt_cnt) + 1) >= REPEAT_FRAMES;

   always_comb begin
      state_nxt = state;
      match_nxt = match_cnt;
      rel_nxt   = rel_cnt;
      rpt_nxt   = rpt_cnt;
      cand_nxt  = cand;
      num_nxt   = num;
      anti_nxt  = Anti;
      unique case (state)
         IDLE: begin
            if (frame_end && res_single) begin
               cand_nxt = res_code;
               if (DEBOUNCE_FRAMES <= 1) begin
                  num_nxt   = res_code;
                  match_nxt = '0;
                  state_nxt = ARM;
               end else begin
                  match_nxt = MW'(1);
                  state_nxt = CONFIRM;
               end
            end
         end
         CONFIRM: begin
            if (frame_end) begin
               if (res_single && (res_code == cand)) begin
                  if (match_done) begin
                     num_nxt   = cand;
                     match_nxt = '0;
                     state_nxt = ARM;
                  end else begin
                     match_nxt = match_cnt + 1'b1;
                  end
               end else begin
                  match_nxt = '0;
                  state_nxt = IDLE;
               end
            end
         end
         // num was loaded on the frame-end clock; Anti falls one clock later
         // so the core always sees a settled code on its falling edge.
         ARM: begin
            anti_nxt  = 1'b0;
            rel_nxt   = '0;
            rpt_nxt   = '0;
            state_nxt = HELD;
         end
         HELD: begin
            if (frame_end) begin
               if (key_hold) begin
                  rel_nxt = '0;
                  if (RPT_EN) begin
                     if (rpt_done) begin
                        rpt_nxt   = '0;
                        anti_nxt  = 1'b1;
                        state_nxt = GAP;
                     end else begin
                        rpt_nxt = rpt_cnt + 1'b1;
                     end
                  end
               end else if (rel_done) begin
                  rel_nxt   = '0;
                  rpt_nxt   = '0;
                  anti_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  rel_nxt = rel_cnt + 1'b1;
               end
            end
         end
         // Autorepeat gap: Anti stays high for one frame. Release counting
         // carries on so that a key let go during the gap still ends the press.
         GAP: begin
            if (frame_end) begin
               if (key_hold) begin
                  rel_nxt   = '0;
                  anti_nxt  = 1'b0;
                  state_nxt = HELD;
               end else if (rel_done) begin
                  rel_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  rel_nxt   = rel_cnt + 1'b1;
                  anti_nxt  = 1'b0;
                  state_nxt = HELD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         match_cnt <= '0;
         rel_cnt   <= '0;
         rpt_cnt   <= '0;
         num       <= 4'hF;
         Anti      <= 1'b1;
         ghost     <= 1'b0;
      end else begin
         state     <= state_nxt;
         match_cnt <= match_nxt;
         rel_cnt   <= rel_nxt;
         rpt_cnt   <= rpt_nxt;
         num       <= num_nxt;
         Anti      <= anti_nxt;
         ghost     <= frame_end & res_multi;
      end
   end

   always_ff @(posedge clk) begin
      cand <= cand_nxt;
   end

endmodule
